// File: rtl/vga_timing_gen.sv
// vga_timing_gen
//
// Generates the pixel/line counters that drive the picture processing unit,
// then takes that unit's 1-bit colour back and emits HSync, VSync and 6-bit
// RGB. Sync and blanking are delayed so that they line up with the colour.
// Also provides line/frame ticks and a frame counter for game logic.
//
// Optional feature macro: TEST_PATTERN_EN
//   When it is defined and pattern_sel=1, a 40x40 checkerboard replaces
//   colour_in. When it is not defined, pattern_sel is unused.
//
// Ports:
//   clk          pixel clock
//   reset        synchronous, active-low
//   pix_en       advance enable (everything holds when low)
//   colour_in    pixel colour returned by the picture processing unit
//   pattern_sel  test-pattern select (only used with TEST_PATTERN_EN)
//   counter_H    current pixel, 0..H_TOTAL-1
//   counter_V    current line, 0..V_TOTAL-1
//   display_on   registered counters are inside the active area (undelayed)
//   line_tick    one-clock pulse when counter_H becomes 0
//   frame_tick   one-clock pulse when the counters wrap to (0,0)
//   frame_count  completed frames, wraps 255->0
//   hsync/vsync  delayed sync at the SYNC_ACTIVE level
//   rgb          delayed colour {R1,G1,B1,R0,G0,B0}, 0 outside the active area

module vga_timing_gen #(
   parameter int         H_ACTIVE       = 640,
   parameter int         H_FRONT        = 16,
   parameter int         H_SYNC         = 96,
   parameter int         H_BACK         = 48,
   parameter int         V_ACTIVE       = 480,
   parameter int         V_FRONT        = 10,
   parameter int         V_SYNC         = 2,
   parameter int         V_BACK         = 33,
   parameter logic       SYNC_ACTIVE    = 1'b0,
   parameter int         COLOUR_LATENCY = 2,
   parameter logic [5:0] FG_RGB         = 6'b111111,
   parameter logic [5:0] BG_RGB         = 6'b000000
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       pix_en,
   input  logic       colour_in,
   input  logic       pattern_sel,
   output logic [9:0] counter_H,
   output logic [9:0] counter_V,
   output logic       display_on,
   output logic       line_tick,
   output logic       frame_tick,
   output logic [7:0] frame_count,
   output logic       hsync,
   output logic       vsync,
   output logic [5:0] rgb
);

   localparam int H_TOTAL = H_ACTIVE + H_FRONT + H_SYNC + H_BACK;
   localparam int V_TOTAL = V_ACTIVE + V_FRONT + V_SYNC + V_BACK;

   localparam logic [9:0] H_LAST   = 10'(H_TOTAL - 1);
   localparam logic [9:0] V_LAST   = 10'(V_TOTAL - 1);
   localparam logic [9:0] H_ACT    = 10'(H_ACTIVE);
   localparam logic [9:0] V_ACT    = 10'(V_ACTIVE);
   localparam logic [9:0] HS_FIRST = 10'(H_ACTIVE + H_FRONT);
   localparam logic [9:0] HS_LAST  = 10'(H_ACTIVE + H_FRONT + H_SYNC - 1);
   localparam logic [9:0] VS_FIRST = 10'(V_ACTIVE + V_FRONT);
   localparam logic [9:0] VS_LAST  = 10'(V_ACTIVE + V_FRONT + V_SYNC - 1);

   generate
      if (COLOUR_LATENCY < 1 || COLOUR_LATENCY > 4) begin : g_latency_check
         $error("vga_timing_gen: COLOUR_LATENCY must be in 1..4");
      end
   endgenerate

   // ------------------------------------------------------------------
   // Counters and ticks
   // ------------------------------------------------------------------
   logic       h_last;
   logic       v_last;
   logic [9:0] h_next;
   logic [9:0] v_next;
   logic       display_next;

   always_comb begin
      h_last       = (counter_H == H_LAST);
      v_last       = (counter_V == V_LAST);
      h_next       = counter_H + 10'd1;
      v_next       = counter_V;
      if (h_last) begin
         h_next = '0;
         v_next = v_last ? '0 : counter_V + 10'd1;
      end
      // display_on is registered from the next counter values so that it
      // describes the counters it is presented alongside.
      display_next = (h_next < H_ACT) && (v_next < V_ACT);
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         counter_H   <= '0;
         counter_V   <= '0;
         display_on  <= 1'b0;
         line_tick   <= 1'b0;
         frame_tick  <= 1'b0;
         frame_count <= '0;
      end else if (pix_en) begin
         counter_H  <= h_next;
         counter_V  <= v_next;
         display_on <= display_next;
         line_tick  <= h_last;
         frame_tick <= h_last && v_last;
         if (h_last && v_last) begin
            frame_count <= frame_count + 8'd1;
         end
      end else begin
         // Ticks mark an edge where the counters moved, so never on a hold.
         line_tick  <= 1'b0;
         frame_tick <= 1'b0;
      end
   end

   // ------------------------------------------------------------------
   // Raw sync levels (1 = asserted) from the registered counters
   // ------------------------------------------------------------------
   logic hsync_raw;
   logic vsync_raw;

   assign hsync_raw = (counter_H >= HS_FIRST) && (counter_H <= HS_LAST);
   assign vsync_raw = (counter_V >= VS_FIRST) && (counter_V <= VS_LAST);

   // ------------------------------------------------------------------
   // Delay line. Stage bundle: [0]=hsync_raw [1]=vsync_raw [2]=blank
   // and, with the test pattern, [3]=pattern pixel.
   // ------------------------------------------------------------------
`ifdef TEST_PATTERN_EN
   localparam int SW = 4;
   logic          pattern_raw;
   logic [SW-1:0] stage_in;

   // Parity of the 40-pixel tile indices gives the checkerboard.
   assign pattern_raw = 1'(counter_H / 10'd40) ^ 1'(counter_V / 10'd40);
   assign stage_in    = {pattern_raw, ~display_on, vsync_raw, hsync_raw};
`else
   localparam int SW = 3;
   logic [SW-1:0] stage_in;
   logic          unused_pattern_sel;

   assign unused_pattern_sel = pattern_sel;
   assign stage_in           = {~display_on, vsync_raw, hsync_raw};
`endif

   // Cleared stages are blank with both syncs inactive.
   localparam logic [SW-1:0] STAGE_IDLE = SW'(4);

   logic [SW-1:0] stage_q [COLOUR_LATENCY];
   logic [SW-1:0] stage_last;

   always_ff @(posedge clk) begin
      if (!reset) begin
         for (int i = 0; i < COLOUR_LATENCY; i++) begin
            stage_q[i] <= STAGE_IDLE;
         end
      end else if (pix_en) begin
         stage_q[0] <= stage_in;
         for (int i = 1; i < COLOUR_LATENCY; i++) begin
            stage_q[i] <= stage_q[i-1];
         end
      end
   end

   assign stage_last = stage_q[COLOUR_LATENCY-1];

   // ------------------------------------------------------------------
   // Output register: colour_in arrives COLOUR_LATENCY clocks after the
   // counters, the same point the last delay stage describes.
   // ------------------------------------------------------------------
   logic pixel;

`ifdef TEST_PATTERN_EN
   assign pixel = pattern_sel ? stage_last[3] : colour_in;
`else
   assign pixel = colour_in;
`endif

   always_ff @(posedge clk) begin
      if (!reset) begin
         hsync <= ~SYNC_ACTIVE;
         vsync <= ~SYNC_ACTIVE;
         rgb   <= '0;
      end else if (pix_en) begin
         hsync <= stage_last[0] ? SYNC_ACTIVE : ~SYNC_ACTIVE;
         vsync <= stage_last[1] ? SYNC_ACTIVE : ~SYNC_ACTIVE;
         rgb   <= stage_last[2] ? 6'b000000 : (pixel ? FG_RGB : BG_RGB);
      end
   end

endmodule
